// File: rtl/dcm_ps_ctrl_if.sv
// Signal bundle between the DCM phase-shift controller, the DCM it drives and
// the logic that requests phase offsets.
interface dcm_ps_ctrl_if;
  logic              LOCKED;
  logic              PSDONE;
  logic              PS_OVERFLOW;
  logic              REQ;
  logic signed [8:0] TARGET;
  logic              DCM_RST;
  logic              PSEN;
  logic              PSINCDEC;
  logic signed [8:0] CUR_SHIFT;
  logic              READY;
  logic              BUSY;
  logic              DONE;
  logic [1:0]        ERR;

  modport master (
    input  LOCKED, PSDONE, PS_OVERFLOW, REQ, TARGET,
    output DCM_RST, PSEN, PSINCDEC, CUR_SHIFT, READY, BUSY, DONE, ERR
  );

  modport slave (
    output LOCKED, PSDONE, PS_OVERFLOW, REQ, TARGET,
    input  DCM_RST, PSEN, PSINCDEC, CUR_SHIFT, READY, BUSY, DONE, ERR
  );
endinterface

// File: rtl/dcm_ps_ctrl.sv
// DCM reset / lock supervisor and one-tap-at-a-time dynamic phase-shift
// stepper on the PSCLK domain; every output comes straight from a register.
module dcm_ps_ctrl #(
  parameter int RST_CYCLES     = 3,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int PSDONE_TIMEOUT = 1023,
  parameter int SHIFT_MIN      = -255,
  parameter int SHIFT_MAX      = 255
) (
  input  logic          PSCLK,
  input  logic          RST,
  dcm_ps_ctrl_if.master bus
);

  localparam int CNT_MAX_A = (LOCK_TIMEOUT > PSDONE_TIMEOUT) ? LOCK_TIMEOUT : PSDONE_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > RST_CYCLES) ? CNT_MAX_A : RST_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PSDONE_LAST = CNT_W'(PSDONE_TIMEOUT - 1);

  localparam logic signed [8:0] SMIN = 9'(SHIFT_MIN);
  localparam logic signed [8:0] SMAX = 9'(SHIFT_MAX);

  typedef enum logic [2:0] {
    S_RST_HOLD,
    S_WAIT_LOCK,
    S_IDLE,
    S_STEP,
    S_WAIT_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic signed [8:0] target_reg, target_next;
  logic signed [8:0] cur_shift_reg, cur_shift_next;
  logic              dcm_rst_reg, dcm_rst_next;
  logic              psen_reg, psen_next;
  logic              psincdec_reg, psincdec_next;
  logic              ready_reg, ready_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [1:0]        err_reg, err_next;

  logic signed [8:0] sat_target;
  logic signed [8:0] shift_step;
  logic              in_run, in_req;
  logic              lock_lost, req_accept, req_equal;
  logic              ps_ok, ps_ovf, ps_tmo, lock_tmo, rst_last, reached;
  logic              fault_entry, req_end;

  always_comb begin
    sat_target = bus.TARGET;
    if (bus.TARGET < SMIN) begin
      sat_target = SMIN;
    end else if (bus.TARGET > SMAX) begin
      sat_target = SMAX;
    end
  end

  // The direction of the outstanding step is whatever PSINCDEC was driven with.
  assign shift_step = psincdec_reg ? (cur_shift_reg + 9'sd1) : (cur_shift_reg - 9'sd1);

  assign in_req     = (state_reg == S_STEP) || (state_reg == S_WAIT_DONE);
  assign in_run     = in_req || (state_reg == S_IDLE);
  assign lock_lost  = in_run && !bus.LOCKED;
  assign req_accept = ready_reg && bus.REQ && bus.LOCKED;
  assign req_equal  = (sat_target == cur_shift_reg);
  assign ps_ok      = (state_reg == S_WAIT_DONE) && bus.LOCKED && bus.PSDONE && !bus.PS_OVERFLOW;
  assign ps_ovf     = (state_reg == S_WAIT_DONE) && bus.LOCKED && bus.PSDONE && bus.PS_OVERFLOW;
  assign ps_tmo     = (state_reg == S_WAIT_DONE) && bus.LOCKED && !bus.PSDONE && (cnt_reg == PSDONE_LAST);
  assign lock_tmo   = (state_reg == S_WAIT_LOCK) && !bus.LOCKED && (cnt_reg == LOCK_LAST);
  assign rst_last   = (state_reg == S_RST_HOLD) && (cnt_reg == RST_LAST);
  assign reached    = (shift_step == target_reg);

  // State register plus every registered output.
  always_ff @(posedge PSCLK or posedge RST) begin
    if (RST) begin
      state_reg     <= S_RST_HOLD;
      cnt_reg       <= '0;
      target_reg    <= '0;
      cur_shift_reg <= '0;
      dcm_rst_reg   <= 1'b1;
      psen_reg      <= 1'b0;
      psincdec_reg  <= 1'b0;
      ready_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 2'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      target_reg    <= target_next;
      cur_shift_reg <= cur_shift_next;
      dcm_rst_reg   <= dcm_rst_next;
      psen_reg      <= psen_next;
      psincdec_reg  <= psincdec_next;
      ready_reg     <= ready_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  // Lock loss outranks everything else, including a PSDONE in the same cycle.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_RST_HOLD: begin
        if (rst_last) state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (bus.LOCKED)    state_next = S_IDLE;
        else if (lock_tmo) state_next = S_RST_HOLD;
      end
      S_IDLE: begin
        if (lock_lost)                      state_next = S_RST_HOLD;
        else if (req_accept && !req_equal)  state_next = S_STEP;
      end
      S_STEP: begin
        if (lock_lost) state_next = S_RST_HOLD;
        else           state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (lock_lost)                      state_next = S_RST_HOLD;
        else if (ps_ok && !reached)         state_next = S_STEP;
        else if (ps_ok || ps_ovf || ps_tmo) state_next = S_IDLE;
      end
      default: state_next = S_RST_HOLD;
    endcase
  end

  assign fault_entry = (state_next == S_RST_HOLD) && (state_reg != S_RST_HOLD);
  assign req_end     = in_req && ((state_next == S_IDLE) || (state_next == S_RST_HOLD));

  always_comb begin
    if ((state_next != state_reg) || (state_next == S_IDLE) || (state_next == S_STEP)) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end

    target_next = req_accept ? sat_target : target_reg;

    // A DCM reset returns the clock to its base phase.
    if (state_next == S_RST_HOLD) begin
      cur_shift_next = '0;
    end else if (ps_ok) begin
      cur_shift_next = shift_step;
    end else begin
      cur_shift_next = cur_shift_reg;
    end

    dcm_rst_next  = (state_next == S_RST_HOLD);
    psen_next     = (state_next == S_STEP);
    psincdec_next = psincdec_reg;
    if (state_next == S_STEP) begin
      psincdec_next = (target_next > cur_shift_next);
    end

    ready_next = (state_next == S_IDLE) && bus.LOCKED;
    busy_next  = (state_next == S_STEP) || (state_next == S_WAIT_DONE);
    done_next  = (req_accept && req_equal) || req_end;

    err_next = err_reg;
    if (fault_entry)     err_next = 2'd3;
    else if (req_accept) err_next = 2'd0;
    else if (ps_ovf)     err_next = 2'd1;
    else if (ps_tmo)     err_next = 2'd2;
  end

  assign bus.DCM_RST   = dcm_rst_reg;
  assign bus.PSEN      = psen_reg;
  assign bus.PSINCDEC  = psincdec_reg;
  assign bus.CUR_SHIFT = cur_shift_reg;
  assign bus.READY     = ready_reg;
  assign bus.BUSY      = busy_reg;
  assign bus.DONE      = done_reg;
  assign bus.ERR       = err_reg;

endmodule

// File: tb/tb_dcm_ps_ctrl.sv
// Bench for dcm_ps_ctrl: a DCM responder model, a transaction-level reference
// model compared against every output on every cycle, and directed scenarios.
module tb_dcm_ps_ctrl;

  localparam int RST_CYC  = 3;
  localparam int LOCK_TO  = 300;
  localparam int PSDN_TO  = 1023;
  localparam int SMIN     = -255;
  localparam int SMAX     = 255;

  logic PSCLK;
  logic RST;

  dcm_ps_ctrl_if bus ();

  dcm_ps_ctrl #(
    .RST_CYCLES    (RST_CYC),
    .LOCK_TIMEOUT  (LOCK_TO),
    .PSDONE_TIMEOUT(PSDN_TO),
    .SHIFT_MIN     (SMIN),
    .SHIFT_MAX     (SMAX)
  ) dut (
    .PSCLK(PSCLK),
    .RST  (RST),
    .bus  (bus)
  );

  initial begin
    PSCLK = 1'b0;
    forever #5 PSCLK = ~PSCLK;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // DCM responder: PSDONE follows each PSEN after a fixed or random latency.
  int ps_fixed_lat = 2;
  bit ps_mute      = 1'b0;
  bit ovf_arm      = 1'b0;

  initial begin
    int ps_cd;
    bit ovf_taken;
    ps_cd = 0;
    ovf_taken = 1'b0;
    bus.PSDONE = 1'b0;
    bus.PS_OVERFLOW = 1'b0;
    forever begin
      @(negedge PSCLK);
      bus.PSDONE = 1'b0;
      bus.PS_OVERFLOW = 1'b0;
      if (!ovf_arm) ovf_taken = 1'b0;
      if (ps_cd > 0) begin
        ps_cd--;
        if (ps_cd == 0) begin
          bus.PSDONE = 1'b1;
          bus.PS_OVERFLOW = ovf_arm && !ovf_taken;
          if (ovf_arm) ovf_taken = 1'b1;
        end
      end
      if (bus.PSEN && !ps_mute) begin
        ps_cd = (ps_fixed_lat != 0) ? ps_fixed_lat : int'($urandom_range(1, 4));
      end
    end
  end

  // Reference model: life cycle of the DCM (reset hold, lock wait, running)
  // and of a request (busy, step issued, step awaiting PSDONE).
  typedef enum {PH_RESET, PH_LOCKWAIT, PH_RUN} ph_t;
  ph_t ph;
  int  hold_left, lock_wait, ps_wait, m_target, m_cur, m_err;
  bit  m_dcm_rst, m_psen, m_psincdec, m_ready, m_busy, m_done, await_ps;

  function automatic int sat(input logic [8:0] v);
    int s;
    s = int'($signed(v));
    if (s < SMIN) s = SMIN;
    if (s > SMAX) s = SMAX;
    return s;
  endfunction

  task automatic model_fault();
    ph        = PH_RESET;
    hold_left = RST_CYC;
    m_err     = 3;
    m_cur     = 0;
    m_busy    = 1'b0;
    await_ps  = 1'b0;
  endtask

  task automatic model_issue();
    m_psen     = 1'b1;
    m_psincdec = (m_target > m_cur);
    await_ps   = 1'b0;
  endtask

  always @(posedge PSCLK or posedge RST) begin
    if (RST) begin
      ph = PH_RESET; hold_left = RST_CYC; lock_wait = 0; ps_wait = 0;
      m_target = 0; m_cur = 0; m_err = 0;
      m_dcm_rst = 1'b1; m_psen = 1'b0; m_psincdec = 1'b0; m_ready = 1'b0;
      m_busy = 1'b0; m_done = 1'b0; await_ps = 1'b0;
    end else begin
      m_done = 1'b0;
      m_psen = 1'b0;
      case (ph)
        PH_RESET: begin
          hold_left--;
          if (hold_left == 0) begin ph = PH_LOCKWAIT; lock_wait = 0; end
        end
        PH_LOCKWAIT: begin
          if (bus.LOCKED) ph = PH_RUN;
          else begin
            lock_wait++;
            if (lock_wait == LOCK_TO) model_fault();
          end
        end
        default: begin
          if (!bus.LOCKED) begin
            if (m_busy) m_done = 1'b1;
            model_fault();
          end else if (m_busy) begin
            if (!await_ps) begin
              await_ps = 1'b1;
              ps_wait = 0;
            end else if (bus.PSDONE) begin
              if (bus.PS_OVERFLOW) begin
                m_err = 1; m_busy = 1'b0; m_done = 1'b1;
              end else begin
                m_cur += m_psincdec ? 1 : -1;
                if (m_cur == m_target) begin m_busy = 1'b0; m_done = 1'b1; end
                else model_issue();
              end
            end else begin
              ps_wait++;
              if (ps_wait == PSDN_TO) begin m_err = 2; m_busy = 1'b0; m_done = 1'b1; end
            end
          end else if (bus.REQ && m_ready) begin
            m_err = 0;
            m_target = sat(bus.TARGET);
            if (m_target == m_cur) m_done = 1'b1;
            else begin m_busy = 1'b1; model_issue(); end
          end
        end
      endcase
      m_dcm_rst = (ph == PH_RESET);
      m_ready   = (ph == PH_RUN) && !m_busy && bus.LOCKED;
    end
  end

  always @(negedge PSCLK) begin
    chk("DCM_RST",   int'(bus.DCM_RST),          int'(m_dcm_rst));
    chk("PSEN",      int'(bus.PSEN),             int'(m_psen));
    chk("PSINCDEC",  int'(bus.PSINCDEC),         int'(m_psincdec));
    chk("CUR_SHIFT", int'($signed(bus.CUR_SHIFT)), m_cur);
    chk("READY",     int'(bus.READY),            int'(m_ready));
    chk("BUSY",      int'(bus.BUSY),             int'(m_busy));
    chk("DONE",      int'(bus.DONE),             int'(m_done));
    chk("ERR",       int'(bus.ERR),              m_err);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int g;
    g = 0;
    while (!bus.READY && g < 2000) begin
      @(negedge PSCLK);
      g++;
    end
    chk("ready_wait", int'(bus.READY), 1);
  endtask

  task automatic run_req(input int t, input int drop_at, input bit glitch,
                         output int n_psen, output int n_done, output int lat,
                         output bit busy_seen);
    n_psen = 0; n_done = 0; lat = -1; busy_seen = 1'b0;
    wait_ready();
    bus.TARGET = 9'(t);
    bus.REQ = 1'b1;
    @(negedge PSCLK);
    bus.REQ = 1'b0;
    for (int g = 0; g < 3000; g++) begin
      if (bus.BUSY) busy_seen = 1'b1;
      if (bus.PSEN) n_psen++;
      if (bus.DONE) begin n_done++; lat = g; break; end
      if (drop_at != 0 && n_psen == drop_at && !bus.PSEN) bus.LOCKED = 1'b0;
      bus.REQ = glitch && bus.BUSY && ($urandom_range(0, 2) == 0);
      if (bus.REQ) bus.TARGET = 9'($urandom);
      @(negedge PSCLK);
    end
    bus.REQ = 1'b0;
    chk("req_done_seen", int'(lat >= 0), 1);
    @(negedge PSCLK);
    if (bus.DONE) n_done++;
    $display("req target=%0d cur=%0d err=%0d psen=%0d done=%0d lat=%0d",
             t, $signed(bus.CUR_SHIFT), bus.ERR, n_psen, n_done, lat);
  endtask

  initial begin
    int np, nd, lt, n, rises, t, drop;
    bit bs, prev;
    RST = 1'b1;
    bus.LOCKED = 1'b0;
    bus.REQ = 1'b0;
    bus.TARGET = '0;
    repeat (5) @(negedge PSCLK);
    RST = 1'b0;

    // Power-up: DCM reset length and READY once LOCKED is seen.
    n = 0;
    while (bus.DCM_RST && n < 20) begin @(negedge PSCLK); n++; end
    chk("dcm_rst_cycles", n, 3);
    repeat (10 - n) @(negedge PSCLK);
    chk("ready_before_lock", int'(bus.READY), 0);
    bus.LOCKED = 1'b1;
    @(negedge PSCLK);
    chk("ready_after_lock", int'(bus.READY), 1);
    chk("cur_after_lock", int'($signed(bus.CUR_SHIFT)), 0);

    ps_fixed_lat = 2;
    run_req(3, 0, 1'b0, np, nd, lt, bs);
    chk("inc3_psen", np, 3);
    chk("inc3_done", nd, 1);
    chk("inc3_cur", int'($signed(bus.CUR_SHIFT)), 3);
    chk("inc3_dir", int'(bus.PSINCDEC), 1);
    chk("inc3_err", int'(bus.ERR), 0);

    run_req(-2, 0, 1'b0, np, nd, lt, bs);
    chk("dec_psen", np, 5);
    chk("dec_cur", int'($signed(bus.CUR_SHIFT)), -2);
    chk("dec_dir", int'(bus.PSINCDEC), 0);

    run_req(-2, 0, 1'b0, np, nd, lt, bs);
    chk("eq_lat", lt, 0);
    chk("eq_psen", np, 0);
    chk("eq_busy", int'(bs), 0);
    chk("eq_done", nd, 1);

    ps_fixed_lat = 1;
    run_req(-256, 0, 1'b0, np, nd, lt, bs);
    chk("sat_psen", np, 253);
    chk("sat_cur", int'($signed(bus.CUR_SHIFT)), -255);

    ps_fixed_lat = 2;
    ovf_arm = 1'b1;
    run_req(2, 0, 1'b0, np, nd, lt, bs);
    ovf_arm = 1'b0;
    chk("ovf_psen", np, 1);
    chk("ovf_err", int'(bus.ERR), 1);
    chk("ovf_cur", int'($signed(bus.CUR_SHIFT)), -255);
    chk("ovf_ready", int'(bus.READY), 1);

    ps_mute = 1'b1;
    run_req(-254, 0, 1'b0, np, nd, lt, bs);
    ps_mute = 1'b0;
    chk("tmo_err", int'(bus.ERR), 2);
    chk("tmo_lat", lt, PSDN_TO + 1);
    chk("tmo_cur", int'($signed(bus.CUR_SHIFT)), -255);

    ps_fixed_lat = 1;
    run_req(0, 0, 1'b0, np, nd, lt, bs);
    chk("home_cur", int'($signed(bus.CUR_SHIFT)), 0);
    chk("home_err", int'(bus.ERR), 0);

    // Lock lost while the third of five steps awaits PSDONE.
    ps_fixed_lat = 3;
    run_req(5, 3, 1'b0, np, nd, lt, bs);
    chk("lol_psen", np, 3);
    chk("lol_done", nd, 1);
    chk("lol_err", int'(bus.ERR), 3);
    chk("lol_cur", int'($signed(bus.CUR_SHIFT)), 0);
    n = 0;
    while (bus.DCM_RST && n < 20) begin @(negedge PSCLK); n++; end
    chk("lol_rst_cycles", n + 1, 3);
    bus.LOCKED = 1'b1;

    // LOCKED held low past the lock timeout: DCM reset is pulsed again.
    wait_ready();
    bus.LOCKED = 1'b0;
    rises = 0;
    prev = bus.DCM_RST;
    repeat (RST_CYC + LOCK_TO + 5) begin
      @(negedge PSCLK);
      if (bus.DCM_RST && !prev) rises++;
      prev = bus.DCM_RST;
    end
    chk("lock_to_pulses", rises, 2);
    chk("lock_to_err", int'(bus.ERR), 3);
    bus.LOCKED = 1'b1;

    // RST in the middle of a request.
    ps_fixed_lat = 2;
    wait_ready();
    bus.TARGET = 9'(10);
    bus.REQ = 1'b1;
    @(negedge PSCLK);
    bus.REQ = 1'b0;
    repeat (5) @(negedge PSCLK);
    chk("mid_busy", int'(bus.BUSY), 1);
    #2 RST = 1'b1;
    #1;
    chk("arst_dcm_rst", int'(bus.DCM_RST), 1);
    chk("arst_psen", int'(bus.PSEN), 0);
    chk("arst_cur", int'($signed(bus.CUR_SHIFT)), 0);
    chk("arst_ready", int'(bus.READY), 0);
    chk("arst_busy", int'(bus.BUSY), 0);
    chk("arst_done", int'(bus.DONE), 0);
    chk("arst_err", int'(bus.ERR), 0);
    repeat (3) @(negedge PSCLK);
    RST = 1'b0;
    wait_ready();

    // Randomised requests with random latency, overflow, timeouts, lock drops
    // and spurious REQ pulses while busy.
    ps_fixed_lat = 0;
    for (int i = 0; i < 30; i++) begin
      t = int'($urandom_range(0, 60)) - 30;
      drop = ($urandom_range(0, 7) == 0) ? 1 : 0;
      ovf_arm = ($urandom_range(0, 7) == 0);
      ps_mute = (i == 9) || (i == 21);
      run_req(t, drop, 1'($urandom_range(0, 1)), np, nd, lt, bs);
      chk("rnd_done_once", nd, 1);
      ovf_arm = 1'b0;
      ps_mute = 1'b0;
      if (!bus.LOCKED) begin
        repeat ($urandom_range(1, 20)) @(negedge PSCLK);
        bus.LOCKED = 1'b1;
      end
    end

    repeat (10) @(negedge PSCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcm_ps_ctrl.md
Name: dcm_ps_ctrl

Overview:
Control stage sitting beside the DCM on the PSCLK domain. It owns the DCM reset and the dynamic phase-shift port. It holds the DCM in reset, waits for LOCKED, then steps PSEN/PSINCDEC one tap at a time until the requested signed phase offset is reached. It recovers from lock loss, PSDONE timeout and phase-shift overflow (STATUS[0]).

Parameters:
RST_CYCLES, 3, DCM_RST high time in PSCLK cycles after RST release or a fault (min 1)
LOCK_TIMEOUT, 65535, PSCLK cycles allowed in WAIT_LOCK before a lock fault
PSDONE_TIMEOUT, 1023, PSCLK cycles allowed between PSEN and PSDONE
SHIFT_MIN, -255, lowest allowed CUR_SHIFT/TARGET
SHIFT_MAX, 255, highest allowed CUR_SHIFT/TARGET

Ports:
PSCLK  input  1  sole clock; all logic on the rising edge
RST  input  1  asynchronous, active-high reset
LOCKED  input  1  DCM LOCKED
PSDONE  input  1  DCM PSDONE, one-cycle pulse
PS_OVERFLOW  input  1  DCM STATUS[0]
REQ  input  1  request pulse; accepted only when READY=1
TARGET  input  9  signed two's-complement target offset, sampled with REQ
DCM_RST  output  1  drives DCM RST
PSEN  output  1  drives DCM PSEN
PSINCDEC  output  1  drives DCM PSINCDEC; 1 = increment
CUR_SHIFT  output  9  signed current offset relative to the DCM power-up phase
READY  output  1  IDLE state and LOCKED=1
BUSY  output  1  request in progress
DONE  output  1  one-cycle pulse that ends every accepted request
ERR  output  2  0 = ok, 1 = overflow, 2 = PSDONE timeout, 3 = lock fault

Behaviour:
- All outputs are registered.
- Reset values (RST high): state RST_HOLD, DCM_RST=1, PSEN=0, PSINCDEC=0, CUR_SHIFT=0, READY=0, BUSY=0, DONE=0, ERR=0, all counters 0.
- RST_HOLD:
  - DCM_RST=1 for exactly RST_CYCLES cycles, then WAIT_LOCK.
  - CUR_SHIFT is forced to 0, because a DCM reset restores the base phase.
- WAIT_LOCK:
  - DCM_RST=0; the counter increments every cycle.
  - LOCKED=1 moves to IDLE.
  - If the counter reaches LOCK_TIMEOUT first: ERR=3, return to RST_HOLD (retry indefinitely).
- IDLE:
  - READY=1 when LOCKED=1.
  - REQ with READY=1 clears ERR and latches TARGET, saturated to [SHIFT_MIN, SHIFT_MAX].
  - If the saturated target equals CUR_SHIFT: DONE pulses on the next cycle, no PSEN, BUSY stays 0.
  - Otherwise BUSY=1 from the next cycle and the state moves to STEP.
- STEP:
  - PSEN=1 for exactly one cycle; PSINCDEC=1 if target > CUR_SHIFT, else 0. PSINCDEC holds its value until the next STEP.
  - Go to WAIT_DONE and clear the timeout counter.
  - The first PSEN occurs on the cycle after REQ is sampled.
- WAIT_DONE, on PSDONE=1:
  - If PS_OVERFLOW=1 in the same cycle: CUR_SHIFT is unchanged, ERR=1, DONE pulse, BUSY=0, go to IDLE.
  - Otherwise CUR_SHIFT ±1. If the new value equals the target: DONE pulse and BUSY=0 on the next cycle, go to IDLE. Else go to STEP.
  - Minimum step period is 2 cycles (STEP, then PSDONE on the first WAIT_DONE cycle).
- WAIT_DONE timeout: if the counter reaches PSDONE_TIMEOUT with no PSDONE: ERR=2, DONE pulse, BUSY=0, go to IDLE with CUR_SHIFT unchanged.
- Lock loss: LOCKED=0 sampled in IDLE, STEP or WAIT_DONE → go to RST_HOLD, ERR=3, BUSY=0, PSEN=0.
  - If a request was in progress, DONE pulses once.
  - Lock loss takes priority over a PSDONE in the same cycle.
- REQ while READY=0 is ignored; it is neither queued nor acknowledged.
- ERR holds its value until the next accepted REQ (exception: the RST_HOLD/WAIT_LOCK retry path sets ERR=3).
- DONE and PSEN never exceed one cycle. PSEN never asserts while DCM_RST=1 or while a previous step awaits PSDONE.
- An RST assertion mid-operation aborts immediately to the reset values. No DONE is generated.

Test Plan:
- RST high 5 cycles, release; LOCKED rises 10 cycles later → DCM_RST high exactly 3 cycles after release, READY=1 one cycle after LOCKED sampled, CUR_SHIFT=0.
- REQ with TARGET=+3, PSDONE returned 2 cycles after each PSEN → three PSEN pulses with PSINCDEC=1, CUR_SHIFT 1,2,3, DONE once, ERR=0. Then TARGET=-2 → five decrement pulses, CUR_SHIFT=-2.
- REQ with TARGET=CUR_SHIFT → DONE on the next cycle, no PSEN, BUSY stays 0. TARGET=0x100 (-256) → saturates to -255.
- REQ +2 with PS_OVERFLOW=1 on the first PSDONE → ERR=1, CUR_SHIFT unchanged, DONE, READY=1. No PSDONE for 1023 cycles → ERR=2, DONE.
- LOCKED dropped in WAIT_DONE of a 5-step request → ERR=3, DONE once, DCM_RST high 3 cycles, CUR_SHIFT=0. LOCKED held low 65535 cycles → DCM_RST re-pulsed, ERR=3.
- REQ pulsed while BUSY, and RST asserted mid-request → the extra REQ is ignored. RST returns all outputs to reset values asynchronously with no DONE.
